// File: rtl/mul_arbiter_if.sv
// Requester and multiplier signals of the shared-multiplier arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the multiplier.
interface mul_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_func3;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [63:0] rsp_result_64;
    logic        rsp_overflow;
    logic        rsp_err;
    logic        busy;
    logic        mul_start;
    logic [31:0] mul_operA;
    logic [31:0] mul_operB;
    logic [2:0]  mul_func3;
    logic [31:0] mul_result;
    logic [63:0] mul_result_64;
    logic        mul_overflow;
    logic        mul_done;

    modport slave (
        input  req_valid, req_a, req_b, req_func3, rsp_ready,
               mul_result, mul_result_64, mul_overflow, mul_done,
        output req_ready, rsp_valid, rsp_result, rsp_result_64, rsp_overflow, rsp_err,
               busy, mul_start, mul_operA, mul_operB, mul_func3
    );

    modport master (
        output req_valid, req_a, req_b, req_func3, rsp_ready,
               mul_result, mul_result_64, mul_overflow, mul_done,
        input  req_ready, rsp_valid, rsp_result, rsp_result_64, rsp_overflow, rsp_err,
               busy, mul_start, mul_operA, mul_operB, mul_func3
    );
endinterface

// File: rtl/mul_arbiter.sv
// Shares one iterative multiplier between the M-extension unit (requester 0) and the
// FPU mantissa multiplier (requester 1), with a watchdog that turns a hang into an error.
module mul_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned FIXED_PRIO     = 0
) (
    input  logic         clk,
    input  logic         rst,
    mul_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_gnt;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [2:0]       r_op_f3;
    logic [31:0]      r_rsp_result;
    logic [63:0]      r_rsp_result_64;
    logic             r_rsp_ovf;
    logic             r_rsp_err;

    logic             w_any;
    logic             w_win;
    logic [1:0]       w_grant_oh;
    logic [1:0]       w_req_ready;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;

    // Winner selection: fixed priority, or favour the requester not served last
    always_comb begin
        w_any = |bus.req_valid;
        if (FIXED_PRIO != 0) begin
            w_win = ~bus.req_valid[0];
        end else if (bus.req_valid[~r_last_grant]) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = r_last_grant;
        end
        w_grant_oh = {w_win, ~w_win} & {2{w_any}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = w_grant_oh;
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // done wins over a timeout landing in the same cycle
                if (bus.mul_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready[r_gnt]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt           <= 1'b0;
            r_last_grant    <= 1'b1;
            r_cnt           <= '0;
            r_op_a          <= '0;
            r_op_b          <= '0;
            r_op_f3         <= '0;
            r_rsp_result    <= '0;
            r_rsp_result_64 <= '0;
            r_rsp_ovf       <= 1'b0;
            r_rsp_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt        <= w_win;
                r_last_grant <= w_win;
                r_cnt        <= '0;
                r_op_a       <= w_win ? bus.req_a[63:32] : bus.req_a[31:0];
                r_op_b       <= w_win ? bus.req_b[63:32] : bus.req_b[31:0];
                r_op_f3      <= w_win ? bus.req_func3[5:3] : bus.req_func3[2:0];
            end else if (r_state == ST_BUSY && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_rsp_result    <= bus.mul_result;
                r_rsp_result_64 <= bus.mul_result_64;
                r_rsp_ovf       <= bus.mul_overflow;
                r_rsp_err       <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_result    <= '0;
                r_rsp_result_64 <= '0;
                r_rsp_ovf       <= 1'b0;
                r_rsp_err       <= 1'b1;
            end
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.rsp_valid     = (r_state == ST_RESP) ? {r_gnt, ~r_gnt} : 2'b00;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_result_64 = r_rsp_result_64;
    assign bus.rsp_overflow  = r_rsp_ovf;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.mul_start     = (r_state == ST_BUSY);
    assign bus.mul_operA     = r_op_a;
    assign bus.mul_operB     = r_op_b;
    assign bus.mul_func3     = r_op_f3;
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: round-robin and fixed-priority instances, each
// driving a behavioural 5-cycle multiplier that can be made to hang.
module tb_mul_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_arbiter_if ifc0 ();
    mul_arbiter_if ifc1 ();

    mul_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    mul_arbiter #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    typedef struct {
        logic        req;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] res;
        logic [63:0] r64;
        logic        ovf;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    logic m0_hang = 1'b0;
    logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (f == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (f == 3'd2 || f == 3'd3) ? {32'd0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic ovf_of(input logic [63:0] p, input logic [2:0] f);
        return (f == 3'd0) && !((&p[63:31]) || !(|p[63:31]));
    endfunction

    // Behavioural multiplier: done rises after start has been high for five edges
    logic [2:0]  m0_cnt, m1_cnt;
    logic [63:0] m0_p, m1_p;
    assign m0_p = prod(ifc0.mul_operA, ifc0.mul_operB, ifc0.mul_func3);
    assign m1_p = prod(ifc1.mul_operA, ifc1.mul_operB, ifc1.mul_func3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_cnt <= '0; ifc0.mul_done <= 1'b0;
            ifc0.mul_result <= '0; ifc0.mul_result_64 <= '0; ifc0.mul_overflow <= 1'b0;
        end else if (!ifc0.mul_start) begin
            m0_cnt <= '0; ifc0.mul_done <= 1'b0;
        end else if (m0_cnt == 3'd4) begin
            if (!m0_hang) begin
                ifc0.mul_done      <= 1'b1;
                ifc0.mul_result    <= (ifc0.mul_func3 == 3'd0) ? m0_p[31:0] : m0_p[63:32];
                ifc0.mul_result_64 <= m0_p;
                ifc0.mul_overflow  <= ovf_of(m0_p, ifc0.mul_func3);
            end
        end else begin
            m0_cnt <= m0_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1_cnt <= '0; ifc1.mul_done <= 1'b0;
            ifc1.mul_result <= '0; ifc1.mul_result_64 <= '0; ifc1.mul_overflow <= 1'b0;
        end else if (!ifc1.mul_start) begin
            m1_cnt <= '0; ifc1.mul_done <= 1'b0;
        end else if (m1_cnt == 3'd4) begin
            ifc1.mul_done      <= 1'b1;
            ifc1.mul_result    <= (ifc1.mul_func3 == 3'd0) ? m1_p[31:0] : m1_p[63:32];
            ifc1.mul_result_64 <= m1_p;
            ifc1.mul_overflow  <= ovf_of(m1_p, ifc1.mul_func3);
        end else begin
            m1_cnt <= m1_cnt + 3'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts negedges after the issue cycle until a response shows up (bounded)
    task automatic await_rsp0(input logic [1:0] drop, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            ifc0.req_valid = ifc0.req_valid & ~drop;
            #1;
            lat++;
        end while (ifc0.rsp_valid == 2'b00 && lat < 40);
    endtask

    task automatic run_vec0(input int idx, input vec_t v);
        int         lat;
        int         r;
        logic [1:0] oh;
        r  = v.req ? 1 : 0;
        oh = v.req ? 2'b10 : 2'b01;
        @(negedge clk);
        ifc0.rsp_ready = 2'b11;
        ifc0.req_a[r*32 +: 32]    = v.a;
        ifc0.req_b[r*32 +: 32]    = v.b;
        ifc0.req_func3[r*3 +: 3]  = v.f;
        ifc0.req_valid            = oh;
        #1;
        chk($sformatf("v%0d req_ready", idx), 64'(ifc0.req_ready), 64'(oh));
        await_rsp0(oh, lat);
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'd7);
        chk($sformatf("v%0d rsp_valid", idx), 64'(ifc0.rsp_valid), 64'(oh));
        chk($sformatf("v%0d result", idx), 64'(ifc0.rsp_result), 64'(v.res));
        chk($sformatf("v%0d result_64", idx), ifc0.rsp_result_64, v.r64);
        chk($sformatf("v%0d overflow", idx), 64'(ifc0.rsp_overflow), 64'(v.ovf));
        chk($sformatf("v%0d err", idx), 64'(ifc0.rsp_err), 64'd0);
        chk($sformatf("v%0d operands", idx), {ifc0.mul_operA, ifc0.mul_operB}, {v.a, v.b});
        chk($sformatf("v%0d start_low", idx), 64'(ifc0.mul_start), 64'd0);
    endtask

    initial begin
        vec_t vecs [8];
        vec_t vpost;
        int   lat;
        int   c;
        vecs[0] = '{1'b0, 32'hFFFFFFFE, 32'd3,        3'd0, 32'hFFFFFFFA, 64'hFFFFFFFFFFFFFFFA, 1'b0};
        vecs[1] = '{1'b1, 32'd7,        32'd6,        3'd0, 32'd42,       64'd42,               1'b0};
        vecs[2] = '{1'b0, 32'h00010000, 32'h00010000, 3'd0, 32'd0,        64'h0000000100000000, 1'b1};
        vecs[3] = '{1'b1, 32'h80000000, 32'd2,        3'd3, 32'd1,        64'h0000000100000000, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'd0,        64'd1,                1'b0};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE, 64'hFFFFFFFE00000001, 1'b0};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd2,        3'd2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0};
        vecs[7] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'd1, 32'h3FFFFFFF, 64'h3FFFFFFF00000001, 1'b0};
        vpost   = '{1'b0, 32'h12345678, 32'h10,       3'd0, 32'h23456780, 64'h0000000123456780, 1'b1};

        ifc0.req_valid = '0; ifc0.req_a = '0; ifc0.req_b = '0; ifc0.req_func3 = '0; ifc0.rsp_ready = 2'b11;
        ifc1.req_valid = '0; ifc1.req_a = '0; ifc1.req_b = '0; ifc1.req_func3 = '0; ifc1.rsp_ready = 2'b11;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset req_ready", 64'(ifc0.req_ready), 64'd0);
        chk("reset rsp_valid", 64'(ifc0.rsp_valid), 64'd0);
        chk("reset busy_start", {62'd0, ifc0.busy, ifc0.mul_start}, 64'd0);
        chk("reset operands", {ifc0.mul_operA, ifc0.mul_operB}, 64'd0);
        chk("reset rsp_fields", {ifc0.rsp_result, 30'd0, ifc0.rsp_overflow, ifc0.rsp_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous first request: requester 0 wins, requester 1 follows
        @(negedge clk);
        ifc0.req_a = {32'h80000000, 32'd7};
        ifc0.req_b = {32'd2, 32'd6};
        ifc0.req_func3 = {3'd3, 3'd0};
        ifc0.req_valid = 2'b11;
        #1;
        chk("sim first grant", 64'(ifc0.req_ready), 64'h1);
        await_rsp0(2'b01, lat);
        chk("sim r0 latency", 64'(lat), 64'd7);
        chk("sim r0 rsp_valid", 64'(ifc0.rsp_valid), 64'h1);
        chk("sim r0 result", 64'(ifc0.rsp_result), 64'd42);
        @(negedge clk);
        #1;
        chk("sim r1 grant", 64'(ifc0.req_ready), 64'h2);
        await_rsp0(2'b10, lat);
        chk("sim r1 rsp_valid", 64'(ifc0.rsp_valid), 64'h2);
        chk("sim r1 result", 64'(ifc0.rsp_result), 64'h1);
        chk("sim r1 result_64", ifc0.rsp_result_64, 64'h0000000100000000);

        for (int i = 0; i < 8; i++) run_vec0(i, vecs[i]);

        // Round-robin with both requesters held valid
        @(negedge clk);
        ifc0.req_a = {32'd3, 32'd5}; ifc0.req_b = {32'd4, 32'd6}; ifc0.req_func3 = '0;
        ifc0.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            c = 0;
            #1;
            while (ifc0.req_ready == 2'b00 && c < 40) begin @(negedge clk); #1; c++; end
            chk($sformatf("rr grant %0d", k), 64'(ifc0.req_ready), 64'(rr_exp[k]));
            @(negedge clk);
        end
        ifc0.req_valid = 2'b00;
        c = 0;
        #1;
        while (ifc0.busy && c < 40) begin @(negedge clk); #1; c++; end
        chk("rr drain", 64'(ifc0.busy), 64'd0);

        // Fixed priority: requester 0 wins every time
        @(negedge clk);
        ifc1.req_a = {32'd3, 32'd5}; ifc1.req_b = {32'd4, 32'd6};
        ifc1.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            c = 0;
            #1;
            while (ifc1.req_ready == 2'b00 && c < 40) begin @(negedge clk); #1; c++; end
            chk($sformatf("fixed grant %0d", k), 64'(ifc1.req_ready), 64'h1);
            @(negedge clk);
        end
        ifc1.req_valid = 2'b00;

        // Backpressure: only the non-granted rsp_ready bit is high for 10 cycles
        @(negedge clk);
        ifc0.rsp_ready = 2'b10;
        ifc0.req_a[31:0] = 32'hFFFFFFFE; ifc0.req_b[31:0] = 32'd3; ifc0.req_func3[2:0] = 3'd0;
        ifc0.req_valid = 2'b01;
        await_rsp0(2'b01, lat);
        chk("bp latency", 64'(lat), 64'd7);
        ifc0.req_a[63:32] = 32'd9; ifc0.req_b[63:32] = 32'd9; ifc0.req_func3[5:3] = 3'd0;
        ifc0.req_valid = 2'b10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d rsp_valid", k), 64'(ifc0.rsp_valid), 64'h1);
            chk($sformatf("bp%0d fields", k), {ifc0.rsp_result, 30'd0, ifc0.rsp_overflow, ifc0.rsp_err},
                {32'hFFFFFFFA, 32'd0});
            chk($sformatf("bp%0d result_64", k), ifc0.rsp_result_64, 64'hFFFFFFFFFFFFFFFA);
            chk($sformatf("bp%0d start_ready", k), {60'd0, ifc0.mul_start, ifc0.req_ready, ifc0.busy},
                64'h1);
        end
        @(negedge clk);
        ifc0.rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        chk("bp release idle", 64'(ifc0.busy), 64'd0);
        chk("bp next grant", 64'(ifc0.req_ready), 64'h2);
        ifc0.rsp_ready = 2'b11;
        await_rsp0(2'b10, lat);
        chk("bp r1 result", 64'(ifc0.rsp_result), 64'd81);

        // Watchdog: multiplier never raises done
        @(negedge clk);
        m0_hang = 1'b1;
        ifc0.req_a[31:0] = 32'd3; ifc0.req_b[31:0] = 32'd4;
        ifc0.req_valid = 2'b01;
        #1;
        chk("to grant", 64'(ifc0.req_ready), 64'h1);
        c = 0;
        do begin
            @(negedge clk);
            ifc0.req_valid = 2'b00;
            #1;
            if (ifc0.mul_start) c++;
        end while (ifc0.mul_start && c < 40);
        chk("to busy cycles", 64'(c), 64'd16);
        chk("to rsp_valid", 64'(ifc0.rsp_valid), 64'h1);
        chk("to err", 64'(ifc0.rsp_err), 64'd1);
        chk("to result_64", ifc0.rsp_result_64, 64'd0);
        chk("to result_ovf", {ifc0.rsp_result, 31'd0, ifc0.rsp_overflow}, 64'd0);
        chk("to start_low", 64'(ifc0.mul_start), 64'd0);
        @(negedge clk);
        m0_hang = 1'b0;

        // Reset while busy, then a clean transaction
        @(negedge clk);
        ifc0.req_a[63:32] = 32'd5; ifc0.req_b[63:32] = 32'd9; ifc0.req_func3[5:3] = 3'd0;
        ifc0.req_valid = 2'b10;
        #1;
        chk("rst grant", 64'(ifc0.req_ready), 64'h2);
        @(negedge clk);
        ifc0.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst pre busy", 64'(ifc0.mul_start), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst busy_start", {62'd0, ifc0.busy, ifc0.mul_start}, 64'd0);
        chk("rst valid_ready", {60'd0, ifc0.rsp_valid, ifc0.req_ready}, 64'd0);
        chk("rst operands", {ifc0.mul_operA, ifc0.mul_operB}, 64'd0);
        chk("rst func3", 64'(ifc0.mul_func3), 64'd0);
        chk("rst rsp_fields", {ifc0.rsp_result, 30'd0, ifc0.rsp_overflow, ifc0.rsp_err}, 64'd0);
        chk("rst result_64", ifc0.rsp_result_64, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_vec0(8, vpost);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
